// File: rtl/wb_conbus_pkg.sv
// Shared constants and FSM encoding for the round-robin Wishbone shared bus.
package wb_conbus_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;
  localparam int TO_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module wb_rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          valid
);

  localparam int unsigned NU = N;

  always_comb begin
    logic [GW-1:0] idx;
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NU; i++) begin
      idx = GW'((32'(last_grant) + i) % NU);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: round-robin arbitration, table decode,
// and err termination for unmapped addresses and stalled slaves.
module wb_conbus_rr
  import wb_conbus_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 8,
  parameter int S_ADDR_W  = 3,
  parameter logic [N_SLAVES*S_ADDR_W-1:0] S_ADDRS =
    {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int TIMEOUT   = 255
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [N_MASTERS*WB_DW-1:0]   m_adr_i,
  input  logic [N_MASTERS*WB_DW-1:0]   m_dat_i,
  input  logic [N_MASTERS*WB_SELW-1:0] m_sel_i,
  input  logic [N_MASTERS-1:0]         m_we_i,
  input  logic [N_MASTERS-1:0]         m_cyc_i,
  input  logic [N_MASTERS-1:0]         m_stb_i,
  output logic [WB_DW-1:0]             m_dat_o,
  output logic [N_MASTERS-1:0]         m_ack_o,
  output logic [N_MASTERS-1:0]         m_err_o,
  output logic [WB_DW-1:0]             s_adr_o,
  output logic [WB_DW-1:0]             s_dat_o,
  output logic [WB_SELW-1:0]           s_sel_o,
  output logic                         s_we_o,
  output logic [N_SLAVES-1:0]          s_cyc_o,
  output logic [N_SLAVES-1:0]          s_stb_o,
  input  logic [N_SLAVES*WB_DW-1:0]    s_dat_i,
  input  logic [N_SLAVES-1:0]          s_ack_i
);

  localparam int GW = $clog2(N_MASTERS);
  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned NS = N_SLAVES;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [TO_W-1:0] to_cnt;

  logic [GW-1:0]   arb_grant;
  logic            arb_valid;

  logic [WB_DW-1:0]   g_adr;
  logic [WB_DW-1:0]   g_dat;
  logic [WB_SELW-1:0] g_sel;
  logic               g_we;
  logic               g_cyc;
  logic               g_stb;

  logic               hit;
  logic [SW-1:0]      hit_idx;
  logic               busy;
  logic               ack;

  wb_rr_arbiter #(
    .N  (N_MASTERS),
    .GW (GW)
  ) u_arb (
    .req        (m_cyc_i),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    g_adr = m_adr_i[grant*WB_DW +: WB_DW];
    g_dat = m_dat_i[grant*WB_DW +: WB_DW];
    g_sel = m_sel_i[grant*WB_SELW +: WB_SELW];
    g_we  = m_we_i[grant];
    g_cyc = m_cyc_i[grant];
    g_stb = m_stb_i[grant];
  end

  // Scan high to low so the lowest matching table entry wins on duplicates.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = NS; k > 0; k--) begin
      if (g_adr[WB_DW-1 -: S_ADDR_W] == S_ADDRS[(k-1)*S_ADDR_W +: S_ADDR_W]) begin
        hit     = 1'b1;
        hit_idx = SW'(k - 1);
      end
    end
  end

  assign busy = (state == BUSY);
  assign ack  = busy && g_cyc && g_stb && hit && s_ack_i[hit_idx];

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = '0;
    s_stb_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state != IDLE) begin
      s_adr_o = g_adr;
      s_dat_o = g_dat;
      s_sel_o = g_sel;
      s_we_o  = g_we;
    end
    if (busy && hit) begin
      s_cyc_o[hit_idx] = g_cyc;
      s_stb_o[hit_idx] = g_cyc & g_stb;
      m_dat_o          = s_dat_i[hit_idx*WB_DW +: WB_DW];
    end
    m_ack_o[grant] = ack;
    m_err_o[grant] = (state == ERR);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_MASTERS - 1);
      to_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (arb_valid) begin
            grant <= arb_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!g_cyc) begin
            state      <= IDLE;
            last_grant <= grant;
            to_cnt     <= '0;
          end else if (!g_stb) begin
            to_cnt <= '0;
          end else if (!hit) begin
            state  <= ERR;
            to_cnt <= '0;
          end else if (s_ack_i[hit_idx]) begin
            // Ack beats a coincident timeout.
            to_cnt <= '0;
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            state  <= ERR;
            to_cnt <= '0;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ERR: begin
          state  <= BUSY;
          to_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
